// File: rtl/mac_acc.sv
// mac_acc: streaming signed accumulator for the MAC product path.
// It sums one group of products per in_last and reports the saturated sum,
// a sticky overflow flag and a saturating term count.
// A single registered result slot uses a valid/ready handshake.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_vld/in_rdy      product beat handshake (in_rdy is combinational)
//   in_data, in_last   signed product and end-of-group marker
//   out_vld/out_rdy    result handshake
//   out_sum            saturated group sum (signed)
//   out_ovf            group clamped at least once
//   out_cnt            number of terms in the group, saturating
module mac_acc #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = SUM_W - IN_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY   = 1'b0,
    PARTIAL = 1'b1
  } phase_t;

  phase_t           phase, phase_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             ovf_acc, ovf_acc_n;
  logic [CNT_W-1:0] cnt_acc, cnt_acc_n;
  logic             out_vld_n;
  logic [ACC_W-1:0] out_sum_n;
  logic             out_ovf_n;
  logic [CNT_W-1:0] out_cnt_n;

  logic             beat;
  logic             take;
  logic [ACC_W-1:0] acc_base;
  logic             ovf_base;
  logic [CNT_W-1:0] cnt_base;
  logic [SUM_W-1:0] sum_raw;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_inc;

  // The single result slot blocks input only while a result is stalled.
  assign in_rdy = !(out_vld && !out_rdy);
  assign beat   = in_vld && in_rdy;
  assign take   = out_vld && out_rdy;

  // Per-beat saturating add; a group starting in EMPTY begins from zero.
  always_comb begin
    acc_base = (phase == EMPTY) ? '0 : acc;
    ovf_base = (phase == EMPTY) ? 1'b0 : ovf_acc;
    cnt_base = (phase == EMPTY) ? '0 : cnt_acc;
    sum_raw  = {acc_base[ACC_W-1], acc_base} + {{EXT_W{in_data[IN_W-1]}}, in_data};
    // One guard bit: overflow iff the two top bits disagree.
    sum_ovf  = sum_raw[SUM_W-1] != sum_raw[SUM_W-2];
    if (sum_ovf) begin
      sum_sat = sum_raw[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sat = sum_raw[ACC_W-1:0];
    end
    cnt_inc = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // Next-state and result-slot logic.
  always_comb begin
    phase_n   = phase;
    acc_n     = acc;
    ovf_acc_n = ovf_acc;
    cnt_acc_n = cnt_acc;
    out_vld_n = out_vld;
    out_sum_n = out_sum;
    out_ovf_n = out_ovf;
    out_cnt_n = out_cnt;

    if (take) begin
      out_vld_n = 1'b0;
    end

    if (beat) begin
      if (in_last) begin
        // A last beat overwrites the slot; with a same-edge take there is no bubble.
        out_vld_n = 1'b1;
        out_sum_n = sum_sat;
        out_ovf_n = ovf_base | sum_ovf;
        out_cnt_n = cnt_inc;
        acc_n     = '0;
        ovf_acc_n = 1'b0;
        cnt_acc_n = '0;
        phase_n   = EMPTY;
      end else begin
        acc_n     = sum_sat;
        ovf_acc_n = ovf_base | sum_ovf;
        cnt_acc_n = cnt_inc;
        phase_n   = PARTIAL;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= EMPTY;
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt_acc <= '0;
      out_vld <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_cnt <= '0;
    end else begin
      phase   <= phase_n;
      acc     <= acc_n;
      ovf_acc <= ovf_acc_n;
      cnt_acc <= cnt_acc_n;
      out_vld <= out_vld_n;
      out_sum <= out_sum_n;
      out_ovf <= out_ovf_n;
      out_cnt <= out_cnt_n;
    end
  end

endmodule

// File: tb/tb_mac_acc.sv
// Testbench for mac_acc: directed scenarios plus randomized traffic,
// compared each cycle against an integer reference model of the group sum.
module tb_mac_acc;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned CNT_W = 8;
  localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (ACC_W - 1));
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  logic             in_rdy;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_vld;
  logic             out_rdy;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: group running sum as plain integers.
  int m_acc = 0, m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_vld = 1'b0;
  int m_sum = 0, m_rcnt = 0;
  bit m_rovf = 1'b0;

  // Results actually taken from the DUT, for directed sequence checks.
  int log_sum[$];
  int log_cnt[$];
  int log_ovf[$];

  always #5 clk = ~clk;

  mac_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .in_last (in_last),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_sum (out_sum),
    .out_ovf (out_ovf),
    .out_cnt (out_cnt)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare at negedge, advance the model, then move past posedge.
  task automatic step();
    int  s;
    int  c;
    bit  o;
    bit  exp_rdy;
    @(negedge clk);
    exp_rdy = !(m_vld && !out_rdy);
    chk("out_vld", longint'(out_vld), longint'(m_vld));
    chk("in_rdy", longint'(in_rdy), longint'(exp_rdy));
    if (m_vld) begin
      chk("out_sum", longint'(int'($signed(out_sum))), longint'(m_sum));
      chk("out_ovf", longint'(out_ovf), longint'(m_rovf));
      chk("out_cnt", longint'(out_cnt), longint'(m_rcnt));
    end
    if (!rst && out_vld && out_rdy) begin
      log_sum.push_back(int'($signed(out_sum)));
      log_ovf.push_back(int'(out_ovf));
      log_cnt.push_back(int'(out_cnt));
    end
    if (rst) begin
      m_vld = 1'b0; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      m_sum = 0; m_rcnt = 0; m_rovf = 1'b0;
    end else begin
      if (m_vld && out_rdy) m_vld = 1'b0;
      if (in_vld && exp_rdy) begin
        s = m_acc + int'($signed(in_data));
        o = 1'b0;
        if (s > ACC_MAX) begin s = ACC_MAX; o = 1'b1; end
        else if (s < ACC_MIN) begin s = ACC_MIN; o = 1'b1; end
        c = (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
        if (in_last) begin
          m_vld = 1'b1; m_sum = s; m_rovf = m_ovf | o; m_rcnt = c;
          m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
        end else begin
          m_acc = s; m_ovf = m_ovf | o; m_cnt = c;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input bit last);
    in_vld  = 1'b1;
    in_data = IN_W'(d);
    in_last = last;
    step();
  endtask

  task automatic idle(input int n);
    in_vld  = 1'b0;
    in_last = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    log_sum.delete();
    log_ovf.delete();
    log_cnt.delete();
  endtask

  task automatic chk_res(input string tag, input int idx, input int s, input int o, input int c);
    if (log_sum.size() > idx) begin
      chk({tag, "_sum"}, longint'(log_sum[idx]), longint'(s));
      chk({tag, "_ovf"}, longint'(log_ovf[idx]), longint'(o));
      chk({tag, "_cnt"}, longint'(log_cnt[idx]), longint'(c));
    end else begin
      chk({tag, "_present"}, longint'(log_sum.size()), longint'(idx + 1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vld"}, longint'(out_vld), 0);
    chk({tag, "_sum"}, longint'(out_sum), 0);
    chk({tag, "_ovf"}, longint'(out_ovf), 0);
    chk({tag, "_cnt"}, longint'(out_cnt), 0);
    chk({tag, "_rdy"}, longint'(in_rdy), 1);
  endtask

  initial begin
    int mode;
    int d;

    rst = 1'b1; in_vld = 1'b0; in_last = 1'b0; in_data = '0; out_rdy = 1'b1;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Dot product 4*i, i = 0..15.
    clear_log();
    for (int i = 0; i < 16; i++) beat(4 * i, i == 15);
    idle(2);
    chk("dot_count", longint'(log_sum.size()), 1);
    chk_res("dot", 0, 480, 0, 16);

    // Positive then negative saturation; overflow must not leak between groups.
    clear_log();
    for (int i = 0; i < 17; i++) beat(32767, i == 16);
    for (int i = 0; i < 17; i++) beat(-32768, i == 16);
    idle(2);
    chk_res("satpos", 0, ACC_MAX, 1, 17);
    chk_res("satneg", 1, ACC_MIN, 1, 17);

    // Near-limit group that never clamps.
    clear_log();
    for (int i = 0; i < 16; i++) beat(32767, 1'b0);
    beat(-32768, 1'b1);
    idle(2);
    chk_res("recover", 0, 491504, 0, 17);

    // Back-to-back single-beat groups.
    clear_log();
    beat(5, 1'b1); beat(-3, 1'b1); beat(7, 1'b1);
    idle(2);
    chk("b2b_count", longint'(log_sum.size()), 3);
    chk_res("b2b0", 0, 5, 0, 1);
    chk_res("b2b1", 1, -3, 0, 1);
    chk_res("b2b2", 2, 7, 0, 1);

    // Backpressure: stalled result, ignored beats, take with overlapping group.
    clear_log();
    out_rdy = 1'b0;
    beat(10, 1'b0); beat(20, 1'b1);
    beat(99, 1'b0); beat(99, 1'b1); beat(99, 1'b0);
    out_rdy = 1'b1;
    beat(1, 1'b0);
    out_rdy = 1'b0;
    beat(2, 1'b1);
    idle(3);
    out_rdy = 1'b1;
    idle(2);
    chk("bp_count", longint'(log_sum.size()), 2);
    chk_res("bp0", 0, 30, 0, 2);
    chk_res("bp1", 1, 3, 0, 2);

    // Reset mid-group discards the partial sum.
    clear_log();
    for (int i = 0; i < 3; i++) beat(100, 1'b0);
    in_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("rst_mid");
    beat(7, 1'b1);
    idle(2);
    chk("rst_mid_count", longint'(log_sum.size()), 1);
    chk_res("rst_mid", 0, 7, 0, 1);

    // Reset with a stalled result pending discards it.
    clear_log();
    out_rdy = 1'b0;
    beat(9, 1'b1);
    in_vld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_rdy = 1'b1;
    chk_reset_outputs("rst_pend");
    idle(2);
    chk("rst_pend_count", longint'(log_sum.size()), 0);

    // Term counter saturates on a long group.
    clear_log();
    for (int i = 0; i < 300; i++) beat(1, i == 299);
    idle(2);
    chk_res("cntsat", 0, 300, 0, CNT_MAX);

    // Randomized traffic with biased magnitudes, stalls and rare resets.
    mode = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst     = ($urandom_range(0, 399) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      in_vld  = ($urandom_range(0, 4) != 0);
      if (mode == 1)      d = int'($urandom_range(20000, 32767));
      else if (mode == 2) d = -int'($urandom_range(20000, 32768));
      else                d = int'($signed(IN_W'($urandom)));
      in_data = IN_W'(d);
      in_last = ($urandom_range(0, 23) == 0) || ($urandom_range(0, 3) == 0 && mode == 0);
      if (in_vld && in_last) mode = int'($urandom_range(0, 2));
      step();
    end
    rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
